// File: rtl/merge6_pkg.sv
// Shared types and defaults for the merge6 two-input packet merge.
package merge6_pkg;

  localparam int unsigned DefaultW    = 9;
  localparam int unsigned DefaultCntW = 16;
  localparam int unsigned AddrHi      = 8;
  localparam int unsigned AddrLo      = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSendS,
    StSendOut
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter: a lone request wins, a tie goes to prio.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt,
  output logic gnt_valid
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt = prio;
    end else begin
      gnt = req1;
    end
  end

endmodule

// File: rtl/merge6.sv
// Two-input packet merge: emits a source-select token on S, then the packet on Out.
// Define MERGE6_FIXED_PRIO_EN to make In0 always win ties instead of round-robin.
module merge6
  import merge6_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic [W-1:0]     In0_data,
  input  logic             In0_valid,
  output logic             In0_ready,
  input  logic [W-1:0]     In1_data,
  input  logic             In1_valid,
  output logic             In1_ready,
  output logic             S_data,
  output logic             S_valid,
  input  logic             S_ready,
  output logic [W-1:0]     Out_data,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
);

  state_e           state_q, state_d;
  logic [W-1:0]     pkt_q, pkt_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             gnt, gnt_valid;

  rr_arb2 u_arb (
    .req0      (In0_valid),
    .req1      (In1_valid),
    .prio      (prio_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Readies come only from state and input valids, never from S_ready/Out_ready.
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    In0_ready = 1'b0;
    In1_ready = 1'b0;
    S_valid   = 1'b0;
    Out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        In0_ready = gnt_valid & ~gnt;
        In1_ready = gnt_valid & gnt;
        if (gnt_valid) begin
          pkt_d   = gnt ? In1_data : In0_data;
          sel_d   = gnt;
          state_d = StSendS;
        end
      end
      StSendS: begin
        S_valid = 1'b1;
        if (S_ready) state_d = StSendOut;
      end
      StSendOut: begin
        Out_valid = 1'b1;
        if (Out_ready) begin
          state_d = StIdle;
`ifdef MERGE6_FIXED_PRIO_EN
          prio_d  = 1'b0;
`else
          prio_d  = ~sel_q;
`endif
          if (sel_q) begin
            cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= StIdle;
      pkt_q   <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign S_data   = sel_q;
  assign Out_data = pkt_q;
  assign Cnt0     = cnt0_q;
  assign Cnt1     = cnt1_q;

endmodule

// File: tb/tb_merge6.sv
// Self-checking bench for merge6: vector table plus back-pressure, reset and wrap sequences.
module tb_merge6;

  localparam int unsigned W  = 9;
  localparam int unsigned CW = 4;

  logic          CLK;
  logic          rst_n;
  logic [W-1:0]  In0_data, In1_data, Out_data;
  logic          In0_valid, In0_ready, In1_valid, In1_ready;
  logic          S_data, S_valid, S_ready, Out_valid, Out_ready;
  logic [CW-1:0] Cnt0, Cnt1;

  merge6 #(.W(W), .CNT_W(CW)) dut (
    .CLK       (CLK),
    ._RESET    (rst_n),
    .In0_data  (In0_data),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1_data  (In1_data),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .S_data    (S_data),
    .S_valid   (S_valid),
    .S_ready   (S_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Cnt0      (Cnt0),
    .Cnt1      (Cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         exp_sel;
    logic [W-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic         sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  vec_t          vecs[6];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [CW-1:0] m_cnt0 = '0;
  logic [CW-1:0] m_cnt1 = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic push_exp(input logic sel, input logic [W-1:0] data);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    sbq.push_back(e);
  endtask

  // Waits for the expected input to be granted, then steps past the accepting edge.
  task automatic wait_accept(input logic sel);
    int n = 0;
    @(negedge CLK);
    while (!(sel ? In1_ready : In0_ready) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      fail_now("accept_timeout", "ready never rose, expected a grant");
    end else begin
      check(sel ? "in0_ready_excl" : "in1_ready_excl",
            32'(sel ? In0_ready : In1_ready), 32'(0));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || S_valid || Out_valid) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) fail_now("drain_timeout", "packets still pending, expected none");
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt0"}, 32'(Cnt0), 32'(m_cnt0));
    check({tag, "_cnt1"}, 32'(Cnt1), 32'(m_cnt1));
  endtask

  task automatic quick_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    sbq.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard side: tokens and packets are compared as their transfers are observed.
  always @(negedge CLK) begin
    if (S_valid && S_ready) begin
      if (sbq.size() == 0) fail_now("unexpected_token", "token seen, expected none");
      else check("s_data", 32'(S_data), 32'(sbq[0].sel));
    end
    if (Out_valid && Out_ready) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_packet", "packet seen, expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_data", 32'(Out_data), 32'(e.data));
        if (e.sel) m_cnt1 = m_cnt1 + CW'(1);
        else m_cnt0 = m_cnt0 + CW'(1);
      end
    end
    if (S_valid || Out_valid) check("ready_in_send", 32'({In0_ready, In1_ready}), 32'(0));
  end

  initial begin
    int last;
    int n;
    vecs[0] = '{1'b1, 9'h1A3, 1'b0, 9'h000, 1'b0, 9'h1A3};
    vecs[1] = '{1'b0, 9'h000, 1'b1, 9'h0AA, 1'b1, 9'h0AA};
`ifdef MERGE6_FIXED_PRIO_EN
    vecs[2] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
    vecs[3] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
    vecs[4] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
    vecs[5] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
`else
    vecs[2] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
    vecs[3] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b1, 9'h1E1};
    vecs[4] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b0, 9'h040};
    vecs[5] = '{1'b1, 9'h040, 1'b1, 9'h1E1, 1'b1, 9'h1E1};
`endif

    rst_n     = 1'b0;
    In0_valid = 1'b0;
    In1_valid = 1'b0;
    In0_data  = '0;
    In1_data  = '0;
    S_ready   = 1'b1;
    Out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;

    check("rst_s_valid", 32'(S_valid), 32'(0));
    check("rst_out_valid", 32'(Out_valid), 32'(0));
    check("rst_s_data", 32'(S_data), 32'(0));
    check("rst_out_data", 32'(Out_data), 32'(0));
    check("rst_readies", 32'({In0_ready, In1_ready}), 32'(0));
    check_cnts("rst");

    // Back-to-back vectors; with both readies high each packet takes 3 cycles.
    last = 0;
    for (int i = 0; i < 6; i++) begin
      In0_valid = vecs[i].v0;
      In0_data  = vecs[i].d0;
      In1_valid = vecs[i].v1;
      In1_data  = vecs[i].d1;
      push_exp(vecs[i].exp_sel, vecs[i].exp_data);
      wait_accept(vecs[i].exp_sel);
      if (i > 0) check("accept_interval", 32'(cyc - last), 32'(3));
      last = cyc;
    end
    In0_valid = 1'b0;
    In1_valid = 1'b0;
    wait_drain();
    check_cnts("table");

    // S then Out back-pressure with a waiting In1 request.
    S_ready   = 1'b0;
    Out_ready = 1'b0;
    In0_valid = 1'b1;
    In0_data  = 9'h155;
    push_exp(1'b0, 9'h155);
    wait_accept(1'b0);
    In0_valid = 1'b0;
    In1_valid = 1'b1;
    In1_data  = 9'h0F0;
    push_exp(1'b1, 9'h0F0);
    repeat (3) begin
      @(negedge CLK);
      check("s_hold_valid", 32'(S_valid), 32'(1));
      check("s_hold_data", 32'(S_data), 32'(0));
    end
    @(posedge CLK);
    #1;
    S_ready = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!Out_valid && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 10) fail_now("out_valid_timeout", "Out_valid low, expected high");
    for (int i = 0; i < 10; i++) begin
      check("out_hold_valid", 32'(Out_valid), 32'(1));
      check("out_hold_data", 32'(Out_data), 32'(9'h155));
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    Out_ready = 1'b1;
    wait_accept(1'b1);
    In1_valid = 1'b0;
    wait_drain();
    check_cnts("bp");

    // Reset mid-packet: drop the in-flight packet, prio returns to In0.
    In0_valid = 1'b1;
    In0_data  = 9'h033;
    push_exp(1'b0, 9'h033);
    wait_accept(1'b0);
    In0_valid = 1'b0;
    wait_drain();
    Out_ready = 1'b0;
    In1_valid = 1'b1;
    In1_data  = 9'h1FF;
    push_exp(1'b1, 9'h1FF);
    wait_accept(1'b1);
    In1_valid = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!Out_valid && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 10) fail_now("pre_reset_timeout", "Out_valid low, expected high");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(Out_valid), 32'(0));
    check("async_s_valid", 32'(S_valid), 32'(0));
    sbq.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
    @(posedge CLK);
    @(negedge CLK);
    rst_n     = 1'b1;
    Out_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_cnt0", 32'(Cnt0), 32'(0));
    check("post_rst_cnt1", 32'(Cnt1), 32'(0));
    repeat (6) @(negedge CLK);
    @(posedge CLK);
    #1;
    In0_valid = 1'b1;
    In0_data  = 9'h011;
    In1_valid = 1'b1;
    In1_data  = 9'h122;
    push_exp(1'b0, 9'h011);
    wait_accept(1'b0);
    In0_valid = 1'b0;
    push_exp(1'b1, 9'h122);
    wait_accept(1'b1);
    In1_valid = 1'b0;
    wait_drain();
    check_cnts("post_rst");

    // Counter wrap with a 4-bit counter: 15 packets, then one more.
    quick_reset();
    In0_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      In0_data = 9'(i * 17);
      push_exp(1'b0, 9'(i * 17));
      wait_accept(1'b0);
    end
    In0_valid = 1'b0;
    wait_drain();
    check("cnt0_full", 32'(Cnt0), 32'(15));
    check_cnts("pre_wrap");
    In0_valid = 1'b1;
    In0_data  = 9'h1C5;
    push_exp(1'b0, 9'h1C5);
    wait_accept(1'b0);
    In0_valid = 1'b0;
    wait_drain();
    check("cnt0_wrap", 32'(Cnt0), 32'(0));
    check("cnt1_wrap", 32'(Cnt1), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
